// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480@60 timing constants and sync polarity encoding
package video_timing_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    typedef enum logic {POL_LOW = 1'b0, POL_HIGH = 1'b1} sync_pol_e;
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pixel enable in, registered raster timing out
interface video_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          ce_pix;
    logic          hs;
    logic          vs;
    logic          de;
    logic          hblank;
    logic          vblank;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic          line_start;
    logic          frame_start;
    modport master (input ce_pix, output hs, vs, de, hblank, vblank, x, y, line_start, frame_start);
    modport slave  (output ce_pix, input hs, vs, de, hblank, vblank, x, y, line_start, frame_start);
endinterface

// File: rtl/video_timing_axis.sv
// video_timing_axis: one raster axis - wrapping counter with registered position, sync and blank
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int        ACTIVE = DEF_H_ACTIVE,
    parameter int        FP     = DEF_H_FP,
    parameter int        SYNC   = DEF_H_SYNC,
    parameter int        BP     = DEF_H_BP,
    parameter sync_pol_e POL    = POL_LOW,
    parameter int        W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         i_en,
    output logic         o_last,
    output logic         o_active,
    output logic         o_sync,
    output logic         o_blank,
    output logic [W-1:0] o_pos
);
    localparam int         TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W:0] A_END = (W+1)'(ACTIVE);
    localparam logic [W:0] S_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0] S_END = (W+1)'(ACTIVE + FP + SYNC);
    localparam logic [W:0] LAST  = (W+1)'(TOTAL - 1);
    localparam logic       LVL   = (POL == POL_HIGH);

    if (ACTIVE < 1 || SYNC < 1 || FP < 0 || BP < 0 || TOTAL > 2**W) begin : g_bad_param
        $error("video_timing_axis: invalid timing parameters");
    end

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_pos;
    logic         r_sync;
    logic         r_blank;
    logic [W:0]   w_cnt;

    // one extra bit so bounds equal to a power-of-two total never truncate
    assign w_cnt    = {1'b0, r_cnt};
    assign o_last   = w_cnt == LAST;
    assign o_active = w_cnt < A_END;
    assign o_sync   = r_sync;
    assign o_blank  = r_blank;
    assign o_pos    = r_pos;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_pos   <= '0;
            r_sync  <= ~LVL;
            r_blank <= 1'b0;
        end else begin
            if (i_en) r_cnt <= o_last ? '0 : r_cnt + 1'b1;
            r_pos   <= r_cnt;
            r_sync  <= (w_cnt >= S_BEG && w_cnt < S_END) ? LVL : ~LVL;
            r_blank <= ~o_active;
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator built from a horizontal and a vertical axis
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int        H_ACTIVE = DEF_H_ACTIVE,
    parameter int        H_FP     = DEF_H_FP,
    parameter int        H_SYNC   = DEF_H_SYNC,
    parameter int        H_BP     = DEF_H_BP,
    parameter int        V_ACTIVE = DEF_V_ACTIVE,
    parameter int        V_FP     = DEF_V_FP,
    parameter int        V_SYNC   = DEF_V_SYNC,
    parameter int        V_BP     = DEF_V_BP,
    parameter sync_pol_e HS_POL   = POL_LOW,
    parameter sync_pol_e VS_POL   = POL_LOW
) (
    input logic               clk_sys,
    input logic               reset_n,
    video_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic w_h_last;
    logic w_h_act;
    logic w_v_last;
    logic w_v_act;
    logic r_hnew;
    logic r_fnew;
    logic r_de;
    logic r_ls;
    logic r_fs;

    video_timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(HW)
    ) u_h (
        .clk_sys(clk_sys), .reset_n(reset_n), .i_en(bus.ce_pix),
        .o_last(w_h_last), .o_active(w_h_act), .o_sync(bus.hs), .o_blank(bus.hblank), .o_pos(bus.x)
    );

    video_timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(VW)
    ) u_v (
        .clk_sys(clk_sys), .reset_n(reset_n), .i_en(bus.ce_pix && w_h_last),
        .o_last(w_v_last), .o_active(w_v_act), .o_sync(bus.vs), .o_blank(bus.vblank), .o_pos(bus.y)
    );

    assign bus.de          = r_de;
    assign bus.line_start  = r_ls;
    assign bus.frame_start = r_fs;

    // r_hnew/r_fnew mark a counter that has just arrived at 0, so a held h=0 pulses only once
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hnew <= 1'b1;
            r_fnew <= 1'b1;
            r_de   <= 1'b0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
        end else begin
            r_hnew <= bus.ce_pix && w_h_last;
            r_fnew <= bus.ce_pix && w_h_last && w_v_last;
            r_de   <= w_h_act && w_v_act;
            r_ls   <= r_hnew;
            r_fs   <= r_fnew;
        end
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 96, horizontal sync width (pixels).
REQ-004 Parameter H_BP, default 48, horizontal back porch (pixels).
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch (lines).
REQ-007 Parameter V_SYNC, default 2, vertical sync width (lines).
REQ-008 Parameter V_BP, default 33, vertical back porch (lines).
REQ-009 Parameter HS_POL, default 0, hs active level (0 active-low, 1 active-high).
REQ-010 Parameter VS_POL, default 0, vs active level (same encoding).
REQ-011 One clock; reset is asynchronous and active-low.
REQ-012 clk_sys  in  1  system clock, all logic on rising edge.
REQ-013 reset_n  in  1  asynchronous active-low reset.
REQ-014 ce_pix  in  1  pixel clock enable; counters advance only on cycles with ce_pix=1.
REQ-015 hs, vs  out  1 each  sync outputs at the level set by HS_POL/VS_POL.
REQ-016 de  out  1  high inside active area only.
REQ-017 hblank, vblank  out  1 each  high outside H_ACTIVE / V_ACTIVE respectively.
REQ-018 x  out  HW  current horizontal count; y  out  VW  current vertical count (HW/VW = clog2 of H/V totals).
REQ-019 line_start, frame_start  out  1 each  single-cycle pulses.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; computed at elaboration.
REQ-021 On ce_pix=1: h increments; at h=H_TOTAL-1 wraps to 0 and v increments; at v=V_TOTAL-1 with h wrap, v wraps to 0.
REQ-022 On ce_pix=0: h, v hold.
REQ-023 All outputs registered; they reflect counter state with exactly one clk_sys cycle latency after the counter update, independent of ce_pix.
REQ-024 hs active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else inactive level.
REQ-025 vs active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else inactive; vs changes aligned to h=0.
REQ-026 de = (h<H_ACTIVE)&&(v<V_ACTIVE); hblank = h>=H_ACTIVE; vblank = v>=V_ACTIVE.
REQ-027 x = h, y = v at full width; no saturation, plain wrap per REQ-021.
REQ-028 line_start high for exactly one clk_sys cycle: the first cycle outputs show h=0, including first cycle after reset release; never repeats while ce_pix=0 holds h=0.
REQ-029 frame_start: same rule for (h,v)=(0,0); coincides with line_start.
REQ-030 Any parameter zero (except porches) or total exceeding counter width is an elaboration error.

Reset
REQ-031 reset_n=0 asynchronously forces h=0, v=0, hs/vs inactive, de=0, hblank=0, vblank=0, x=0, y=0, line_start=0, frame_start=0.
REQ-032 Reset mid-frame abandons the frame; no partial-line completion.
REQ-033 First clk_sys edge after release: outputs show (0,0), de=1, line_start=frame_start=1.

Structure
REQ-034 Package video_timing_pkg holds default 640x480 timing constants and a sync-polarity enum.
REQ-035 One sub-module video_timing_axis (counter + wrap + sync/blank decode, parametrised by active/fp/sync/bp/pol), instantiated for horizontal and vertical.

Verification
REQ-036 Defaults, ce_pix=1 constant -> hs low 96 clks starting at h=656, line period 800 clks, frame 420000 clks, vs low lines 490-491.
REQ-037 ce_pix every 4th clk -> line period 3200 clks; line_start exactly 1 clk wide per line.
REQ-038 HS_POL=1, VS_POL=1 -> hs idles low, high 96 pixels; reset value hs=0, vs=0.
REQ-039 reset_n low at h=300,v=200 -> all outputs at reset values same cycle; after release x=0,y=0,de=1,frame_start=1 one cycle.
REQ-040 State h=799,v=524, ce_pix=1 -> next outputs x=0,y=0, line_start=frame_start=1, vblank=0.
REQ-041 H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1 -> line 8 pixels, frame 48 pixels, hs active x=5-6.
